argmax_classifier: RTL and testbench
====================================

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 The block SHALL have parameter N_CLASSES, default 10, number of logits scanned (legal range 2..16).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  level request; the run begins when sampled high in IDLE.
REQ-005 The block SHALL have port logits[0:N_CLASSES-1]  input  32 signed each  scores produced by the fully connected output layer.
REQ-006 The block SHALL have port done  output  1  result valid / run complete.
REQ-007 The block SHALL have port class_id  output  4  index of the largest logit.
REQ-008 The block SHALL have port max_score  output  32 signed  value of the largest logit.
REQ-009 The block SHALL have port second_id  output  4  index of the runner-up logit.
REQ-010 The block SHALL have port margin  output  32 unsigned  max_score minus runner-up score, saturated.

Function
REQ-011 The state machine SHALL have states IDLE, SCAN, DONE and WAIT_START_LOW.
REQ-012 IDLE with start=1 at edge T SHALL snapshot all logits into internal registers, clear done, load best=logit[0], best_idx=0, second=-2^31, second_idx=0, idx=1, and go to SCAN.
REQ-013 Logits SHALL be read only at edge T; changes after T SHALL NOT affect the result.
REQ-014 SCAN SHALL process exactly one snapshot element (idx) per edge, then increment idx.
REQ-015 If elem > best (signed, strict), the scan SHALL move best/best_idx into second/second_idx and load elem/idx into best.
REQ-016 Otherwise, if elem > second (signed, strict), the scan SHALL load elem/idx into second/second_idx.
REQ-017 Ties SHALL resolve to the lowest index: an element equal to best SHALL become the runner-up when it exceeds second, never best.
REQ-018 SCAN SHALL go to DONE on the edge that processes idx = N_CLASSES-1.
REQ-019 DONE SHALL register class_id, max_score, second_id and margin, set done=1, and go to WAIT_START_LOW; done SHALL be high after edge T+N_CLASSES.
REQ-020 margin SHALL be computed in 33-bit signed (best - second) and clamped to 32'hFFFFFFFF when the result exceeds 2^32-1; it SHALL never be negative.
REQ-021 WAIT_START_LOW SHALL go to IDLE only when start=0; start held high SHALL NOT retrigger a run.
REQ-022 done and all result outputs SHALL hold their values through WAIT_START_LOW and IDLE until the next accepted start, which clears done only.
REQ-023 start SHALL be ignored in SCAN, DONE and WAIT_START_LOW.
REQ-024 Result outputs SHALL update only in DONE; intermediate scan values SHALL NOT appear on the outputs.

Reset
REQ-025 When reset is asserted (at any time, including mid-SCAN), the block SHALL enter IDLE immediately (asynchronously).
REQ-026 While reset is asserted, done, class_id, second_id, max_score and margin SHALL be 0.
REQ-027 While reset is asserted, idx and the snapshot SHALL be cleared.
REQ-028 After reset deasserts, the first run SHALL start only on a start sampled high in IDLE.

Verification
REQ-029 Logits {5,-3,100,7,0,0,0,0,0,99}, start pulse -> done rises 10 cycles after start sampled; class_id=2, max_score=100, second_id=9, margin=1.
REQ-030 Logits all -7 -> class_id=0, second_id=1, max_score=-7, margin=0.
REQ-031 logit[4]=2147483647, logit[7]=-2147483648, others -2147483648 -> class_id=4, second_id=0, margin=32'hFFFFFFFF (saturated).
REQ-032 start held high for 30 cycles; logits changed at cycle 3 -> exactly one done; result reflects cycle-0 logits; no new run until start falls and rises again.
REQ-033 reset pulsed at SCAN idx=5 -> outputs 0 and done=0 immediately; a later start yields a correct full run.
REQ-034 Two back-to-back runs with different logits -> done drops on the second accepted start; the first results hold until the second DONE.

Source files
------------

// File: rtl/argmax_classifier_if.sv
// rtl/argmax_classifier_if.sv - request/result bundle for the argmax classifier
interface argmax_classifier_if #(
  parameter int N_CLASSES = 10
);
  logic                start;
  logic signed [31:0]  logits [0:N_CLASSES-1];
  logic                done;
  logic [3:0]          class_id;
  logic signed [31:0]  max_score;
  logic [3:0]          second_id;
  logic [31:0]         margin;

  modport master (
    output start, logits,
    input  done, class_id, max_score, second_id, margin
  );

  modport slave (
    input  start, logits,
    output done, class_id, max_score, second_id, margin
  );
endinterface

// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - sequential top-two scan over a snapshot of N_CLASSES signed logits
module argmax_classifier #(
  parameter int N_CLASSES = 10
) (
  input logic                clk,
  input logic                reset,
  argmax_classifier_if.slave bus
);

  localparam logic [3:0]         LAST_IDX  = 4'(N_CLASSES - 1);
  localparam logic signed [31:0] MIN_SCORE = 32'sh8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE,
    WAIT_START_LOW
  } state_t;

  state_t state, state_next;

  logic signed [31:0] snap [0:N_CLASSES-1];
  logic signed [31:0] best;
  logic signed [31:0] second;
  logic [3:0]         best_idx;
  logic [3:0]         second_idx;
  logic [3:0]         idx;
  logic signed [31:0] elem;

  logic [33:0]        diff;
  logic [31:0]        margin_sat;

  logic               done_r;
  logic [3:0]         class_id_r;
  logic signed [31:0] max_score_r;
  logic [3:0]         second_id_r;
  logic [31:0]        margin_r;

  assign bus.done      = done_r;
  assign bus.class_id  = class_id_r;
  assign bus.max_score = max_score_r;
  assign bus.second_id = second_id_r;
  assign bus.margin    = margin_r;

  assign elem = snap[idx];

  // Two guard bits keep the difference of two full-range signed values exact.
  assign diff = {{2{best[31]}}, best} - {{2{second[31]}}, second};

  always_comb begin
    margin_sat = diff[31:0];
    if (diff[33]) begin
      margin_sat = 32'd0;
    end else if (diff[32]) begin
      margin_sat = 32'hFFFF_FFFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:           if (bus.start) state_next = SCAN;
      SCAN:           if (idx == LAST_IDX) state_next = DONE;
      DONE:           state_next = WAIT_START_LOW;
      WAIT_START_LOW: if (!bus.start) state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CLASSES; i++) begin
        snap[i] <= '0;
      end
      best        <= '0;
      second      <= '0;
      best_idx    <= '0;
      second_idx  <= '0;
      idx         <= '0;
      done_r      <= 1'b0;
      class_id_r  <= '0;
      max_score_r <= '0;
      second_id_r <= '0;
      margin_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < N_CLASSES; i++) begin
              snap[i] <= bus.logits[i];
            end
            done_r     <= 1'b0;
            best       <= bus.logits[0];
            best_idx   <= 4'd0;
            second     <= MIN_SCORE;
            second_idx <= 4'd0;
            idx        <= 4'd1;
          end
        end
        SCAN: begin
          // Strict compares keep the earliest index on ties.
          if (elem > best) begin
            second     <= best;
            second_idx <= best_idx;
            best       <= elem;
            best_idx   <= idx;
          end else if (elem > second) begin
            second     <= elem;
            second_idx <= idx;
          end
          idx <= idx + 4'd1;
        end
        DONE: begin
          done_r      <= 1'b1;
          class_id_r  <= best_idx;
          max_score_r <= best;
          second_id_r <= second_idx;
          margin_r    <= margin_sat;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// tb/tb_argmax_classifier.sv - scoreboard bench for argmax_classifier against a top-two reference model
module tb_argmax_classifier;

  localparam int N = 10;
  localparam logic signed [31:0] SMIN = 32'sh8000_0000;
  localparam logic signed [31:0] SMAX = 32'sh7FFF_FFFF;

  typedef struct {
    logic [3:0]         cid;
    logic signed [31:0] ms;
    logic [3:0]         sid;
    logic [31:0]        mg;
    int                 acc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   errors;
  int   checks;
  int   done_rises;
  logic prev_done;

  exp_t sb[$];
  logic signed [31:0] v [0:N-1];

  argmax_classifier_if #(.N_CLASSES(N)) bus ();

  argmax_classifier #(.N_CLASSES(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Top score is the first occurrence of the maximum; runner-up is the best of
  // the remaining entries (earliest on ties), index 0 when nothing beats the floor.
  function automatic exp_t model(input logic signed [31:0] lv [0:N-1]);
    exp_t   e;
    int     bi;
    int     si;
    logic signed [31:0] sv;
    longint d;
    bi = 0;
    for (int i = 1; i < N; i++) if (lv[i] > lv[bi]) bi = i;
    sv = SMIN;
    for (int j = 0; j < N; j++) if (j != bi && lv[j] > sv) sv = lv[j];
    si = 0;
    if (sv != SMIN) begin
      for (int j = N - 1; j >= 0; j--) if (j != bi && lv[j] == sv) si = j;
    end
    d = longint'(lv[bi]) - longint'(sv);
    e.cid = 4'(bi);
    e.ms  = lv[bi];
    e.sid = 4'(si);
    e.mg  = (d > 64'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : d[31:0];
    e.acc = 0;
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (!reset && bus.done && !prev_done) begin
      done_rises++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("latency", 64'(cyc - e.acc), 64'(N));
        chk("class_id", 64'(bus.class_id), 64'(e.cid));
        chk("max_score", 64'(bus.max_score), 64'(e.ms));
        chk("second_id", 64'(bus.second_id), 64'(e.sid));
        chk("margin", 64'(bus.margin), 64'(e.mg));
      end
    end
    prev_done = bus.done;
  end

  task automatic start_run(input logic signed [31:0] lv [0:N-1], input int hold, input int change_at);
    exp_t e;
    @(negedge clk);
    bus.logits = lv;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    e     = model(lv);
    e.acc = cyc;
    sb.push_back(e);
    for (int k = 1; k < hold; k++) begin
      @(negedge clk);
      if (k == change_at) begin
        for (int i = 0; i < N; i++) bus.logits[i] = $urandom;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_rise(input int r0);
    int k;
    k = 0;
    while (done_rises == r0 && k < 100) begin
      @(posedge clk);
      #3;
      k++;
    end
    if (done_rises == r0) chk("done_timeout", 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_v(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       v[i] = $urandom;
        1:       v[i] = int'($urandom_range(0, 6)) - 3;
        default: v[i] = ($urandom_range(0, 1) == 1) ? SMAX : SMIN;
      endcase
    end
  endtask

  initial begin
    exp_t ea;
    int   r0;
    errors     = 0;
    checks     = 0;
    done_rises = 0;
    prev_done  = 1'b0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    for (int i = 0; i < N; i++) bus.logits[i] = '0;

    repeat (2) @(negedge clk);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_class_id", 64'(bus.class_id), 64'd0);
    chk("rst_max_score", 64'(bus.max_score), 64'd0);
    chk("rst_second_id", 64'(bus.second_id), 64'd0);
    chk("rst_margin", 64'(bus.margin), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    v = '{5, -3, 100, 7, 0, 0, 0, 0, 0, 99};
    r0 = done_rises; start_run(v, 1, 0); wait_rise(r0);

    for (int i = 0; i < N; i++) v[i] = -7;
    r0 = done_rises; start_run(v, 1, 0); wait_rise(r0);

    for (int i = 0; i < N; i++) v[i] = SMIN;
    v[4] = SMAX;
    r0 = done_rises; start_run(v, 1, 0); wait_rise(r0);
    chk("sat_margin", 64'(bus.margin), 64'hFFFF_FFFF);

    set_v(0);
    r0 = done_rises; start_run(v, 30, 3);
    repeat (10) @(negedge clk);
    chk("held_start_one_done", 64'(done_rises - r0), 64'd1);
    repeat (2) @(negedge clk);

    // Abort a scan after idx has reached 5; outputs hold a prior nonzero result.
    set_v(0);
    @(negedge clk);
    bus.logits = v;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midscan_rst_done", 64'(bus.done), 64'd0);
    chk("midscan_rst_class_id", 64'(bus.class_id), 64'd0);
    chk("midscan_rst_max_score", 64'(bus.max_score), 64'd0);
    chk("midscan_rst_margin", 64'(bus.margin), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    r0 = done_rises;
    repeat (20) @(negedge clk);
    chk("no_run_without_start", 64'(done_rises - r0), 64'd0);
    set_v(1);
    r0 = done_rises; start_run(v, 1, 0); wait_rise(r0);

    set_v(0);
    ea = model(v);
    r0 = done_rises; start_run(v, 1, 0); wait_rise(r0);
    set_v(0);
    @(negedge clk);
    bus.logits = v;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    ea.acc = cyc;
    chk("b2b_done_cleared", 64'(bus.done), 64'd0);
    chk("b2b_class_id_hold", 64'(bus.class_id), 64'(ea.cid));
    begin
      exp_t eb;
      eb     = model(v);
      eb.acc = cyc;
      sb.push_back(eb);
    end
    r0 = done_rises;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_max_score_hold", 64'(bus.max_score), 64'(ea.ms));
    chk("b2b_margin_hold", 64'(bus.margin), 64'(ea.mg));
    wait_rise(r0);

    for (int t = 0; t < 20; t++) begin
      set_v(int'($urandom_range(0, 2)));
      r0 = done_rises;
      start_run(v, int'($urandom_range(1, 15)), 0);
      wait_rise(r0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
